// File: rtl/converter_pkg.sv
// Shared types and constants for the round-robin two's-complement to BCD converter.
package converter_pkg;

    localparam int MAX_DW = 10;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

    typedef struct packed {
        logic       sign;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
    } dec_result_t;

endpackage

// File: rtl/converter_c2_to_decimal.sv
// Combinational two's-complement to sign + three BCD digits (|x| <= 512).
module converter_c2_to_decimal
    import converter_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_operand,
    output dec_result_t   o_result
);

    logic              w_sign;
    logic [DW-1:0]     w_abs;
    logic [MAX_DW-1:0] w_mag;
    logic [MAX_DW-1:0] w_hund;
    logic [MAX_DW-1:0] w_rem;
    logic [MAX_DW-1:0] w_tens;
    logic [MAX_DW-1:0] w_units;

    // Negating the most negative value wraps to 2^(DW-1), which is the correct unsigned magnitude.
    assign w_sign  = i_operand[DW-1];
    assign w_abs   = w_sign ? (~i_operand + 1'b1) : i_operand;
    assign w_mag   = MAX_DW'(w_abs);
    assign w_hund  = w_mag / MAX_DW'(100);
    assign w_rem   = w_mag % MAX_DW'(100);
    assign w_tens  = w_rem / MAX_DW'(10);
    assign w_units = w_rem % MAX_DW'(10);

    assign o_result.sign     = w_sign;
    assign o_result.hundreds = w_hund[3:0];
    assign o_result.tens     = w_tens[3:0];
    assign o_result.units    = w_units[3:0];

endmodule

// File: rtl/converter_rr_scheduler.sv
// Round-robin scheduler sharing one converter_c2_to_decimal among NREQ requesters.
module converter_rr_scheduler
    import converter_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IW-1:0]      res_id,
    output logic               res_sign,
    output logic [3:0]         res_hundreds,
    output logic [3:0]         res_tens,
    output logic [3:0]         res_units,
    output logic               busy
);

    localparam int unsigned NREQ_U = NREQ;

    conv_state_t r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_id;
    logic [DW-1:0] r_operand;
    logic [IW-1:0] r_res_id;
    logic          r_res_valid;
    dec_result_t   r_res;

    logic [IW:0]   w_pick;
    logic          w_found;
    logic [IW-1:0] w_gnt_idx;
    dec_result_t   w_conv;

    // Returns {found, index} of the first valid bit at or after ptr, wrapping modulo NREQ.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IW-1:0] ptr);
        logic [IW:0]   pick;
        logic [IW-1:0] sel;
        int unsigned   idx;
        pick = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            idx = (32'(ptr) + i) % NREQ_U;
            sel = IW'(idx);
            if (!pick[IW] && valid[sel]) begin
                pick = {1'b1, sel};
            end
        end
        return pick;
    endfunction

    assign w_pick    = rr_pick(req_valid, r_ptr);
    assign w_found   = w_pick[IW];
    assign w_gnt_idx = w_pick[IW-1:0];
    assign req_ready = (r_state == IDLE && w_found) ? (NREQ'(1) << w_gnt_idx) : '0;

    converter_c2_to_decimal #(.DW(DW)) u_conv (
        .i_operand (r_operand),
        .o_result  (w_conv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_operand   <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_operand <= req_data[w_gnt_idx*DW +: DW];
                        r_id      <= w_gnt_idx;
                        r_ptr     <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_res       <= w_conv;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign res_valid    = r_res_valid;
    assign res_id       = r_res_id;
    assign res_sign     = r_res.sign;
    assign res_hundreds = r_res.hundreds;
    assign res_tens     = r_res.tens;
    assign res_units    = r_res.units;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_converter_rr_scheduler.sv
// Directed self-checking bench for converter_rr_scheduler (DW=8, NREQ=4).
module tb_converter_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic        res_sign;
    logic [3:0]  res_hundreds;
    logic [3:0]  res_tens;
    logic [3:0]  res_units;
    logic        busy;

    int checks;
    int failures;

    converter_rr_scheduler #(.DW(8), .NREQ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_sign     (res_sign),
        .res_hundreds (res_hundreds),
        .res_tens     (res_tens),
        .res_units    (res_units),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [1:0] id, input logic s,
                           input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_id"}, 32'(res_id), 32'(id));
        chk({tag, "_sign"}, 32'(res_sign), 32'(s));
        chk({tag, "_digits"}, {20'd0, res_hundreds, res_tens, res_units}, {20'd0, h, t, u});
    endtask

    // One full transaction from a single requester, consumed immediately.
    task automatic do_conv(input string tag, input int idx, input logic [7:0] d,
                           input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        logic [3:0] mask;
        mask = 4'(1 << idx);
        req_data = '0;
        req_data[idx*8 +: 8] = d;
        req_valid = mask;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'(mask));
        tick();
        req_valid = '0;
        chk({tag, "_conv_busy"}, 32'(busy), 32'd1);
        chk({tag, "_conv_nores"}, 32'(res_valid), 32'd0);
        tick();
        chk_res(tag, 2'(idx), s, h, t, u);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_drop"}, 32'(res_valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] fdata[4];
    logic [3:0] snap;
    int wait_cnt;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_digits", {19'd0, res_sign, res_hundreds, res_tens, res_units}, 32'd0);
        rst = 1'b0;
        tick();

        do_conv("single85", 0, 8'h85, 1'b1, 4'd1, 4'd2, 4'd3);

        vecs[0] = '{8'h80, 1'b1, 4'd1, 4'd2, 4'd8};
        vecs[1] = '{8'h7F, 1'b0, 4'd1, 4'd2, 4'd7};
        vecs[2] = '{8'h00, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[3] = '{8'hFF, 1'b1, 4'd0, 4'd0, 4'd1};
        vecs[4] = '{8'h9C, 1'b1, 4'd1, 4'd0, 4'd0};
        vecs[5] = '{8'h63, 1'b0, 4'd0, 4'd9, 4'd9};
        vecs[6] = '{8'h01, 1'b0, 4'd0, 4'd0, 4'd1};
        for (int k = 0; k < 7; k++) begin
            do_conv($sformatf("bnd%0h", vecs[k].d), (k + 1) % 4, vecs[k].d,
                    vecs[k].s, vecs[k].h, vecs[k].t, vecs[k].u);
        end

        // Pointer is back at 0 here: fairness should give ids 0,1,2,3,0.
        fdata[0] = 8'd10; fdata[1] = 8'd20; fdata[2] = 8'd30; fdata[3] = 8'd40;
        req_data = {fdata[3], fdata[2], fdata[1], fdata[0]};
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_cnt = 0;
            while (!res_valid && wait_cnt < 10) begin
                tick();
                wait_cnt++;
            end
            if (!res_valid) chk("fair_timeout", 32'd0, 32'd1);
            chk_res($sformatf("fair%0d", k), 2'(k % 4), 1'b0, 4'd0,
                    4'(fdata[k % 4] / 8'd10), 4'd0);
            tick();
        end
        req_valid = '0;
        res_ready = 1'b0;

        // Backpressure: pointer at 1 after the fifth grant.
        req_data = '0;
        req_data[15:8] = 8'hF6;
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        req_data[31:24] = 8'h33;
        req_valid = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            chk_res($sformatf("bp_hold%0d", k), 2'd1, 1'b1, 4'd0, 4'd1, 4'd0);
            snap = req_ready;
            chk($sformatf("bp_ready%0d", k), 32'(snap), 32'd0);
            chk($sformatf("bp_busy%0d", k), 32'(busy), 32'd1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_release_valid", 32'(res_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_new_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        chk_res("bp_next", 2'd3, 1'b0, 4'd0, 4'd5, 4'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Abort: reset while requester 2 is in CONV.
        req_data = '0;
        req_data[23:16] = 8'h85;
        req_valid = 4'b0100;
        #1;
        chk("abort_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("abort_in_conv", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_digits", {19'd0, res_sign, res_hundreds, res_tens, res_units}, 32'd0);
        tick();
        chk("abort_no_pulse", 32'(res_valid), 32'd0);
        rst = 1'b0;
        tick();
        req_valid = 4'b1111;
        #1;
        chk("abort_first_grant0", 32'(req_ready), 32'b0001);
        req_valid = '0;
        #1;
        do_conv("abort_retry", 2, 8'h85, 1'b1, 4'd1, 4'd2, 4'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
